// File: rtl/demux1to4_tdm.sv
// 1:4 time-division demultiplexer: locks onto sync-marked frames of four words
// and presents each complete frame on four registered output channels.
module demux1to4_tdm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             frame_valid,
    output logic             locked,
    output logic             sync_err
);

    typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

    state_t                      state_q;
    logic [1:0]                  slot_q;
    logic [3:0][WIDTH-1:0]       stg_q, stg_d;
    logic [3:0][WIDTH-1:0]       out_q;
    logic                        fv_q, err_q;
    logic                        stg_wr;
    logic [1:0]                  stg_idx;

    // A sync word always restarts staging at slot 0; plain words land only mid-frame.
    assign stg_wr  = in_valid && (sync || (state_q == LOCK && slot_q != 2'd0));
    assign stg_idx = sync ? 2'd0 : slot_q;

    always_comb begin
        stg_d = stg_q;
        if (stg_wr) stg_d[stg_idx] = in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            slot_q  <= 2'd0;
            stg_q   <= '0;
            out_q   <= '0;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            fv_q  <= 1'b0;
            err_q <= 1'b0;
            stg_q <= stg_d;
            if (in_valid) begin
                case (state_q)
                    HUNT: begin
                        if (sync) begin
                            slot_q  <= 2'd1;
                            state_q <= LOCK;
                        end
                    end
                    LOCK: begin
                        if (sync) begin
                            err_q  <= (slot_q != 2'd0);
                            slot_q <= 2'd1;
                        end else if (slot_q == 2'd0) begin
                            err_q   <= 1'b1;
                            state_q <= HUNT;
                        end else begin
                            slot_q <= slot_q + 2'd1;
                            if (slot_q == 2'd3) begin
                                out_q <= stg_d;
                                fv_q  <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

    assign out0        = out_q[0];
    assign out1        = out_q[1];
    assign out2        = out_q[2];
    assign out3        = out_q[3];
    assign frame_valid = fv_q;
    assign sync_err    = err_q;
    assign locked      = (state_q == LOCK);

endmodule

// File: tb/tb_demux1to4_tdm.sv
// Bench for demux1to4_tdm: directed frame scenarios plus randomized traffic,
// checked every cycle against a queue-based frame model.
module tb_demux1to4_tdm;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] in;
    logic         in_valid;
    logic         sync;
    logic [W-1:0] out0, out1, out2, out3;
    logic         frame_valid, locked, sync_err;

    int n_cmp = 0;
    int n_err = 0;
    int fv_cnt = 0;

    demux1to4_tdm #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid), .sync(sync),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    // Model: a frame is a list of words collected since the last sync.
    logic [W-1:0] q[$];
    bit           m_lock;
    logic [W-1:0] m_out[4];
    bit           m_fv, m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_lock = 0;
            m_fv   = 0;
            m_err  = 0;
            for (int i = 0; i < 4; i++) m_out[i] = '0;
        end else begin
            m_fv  = 0;
            m_err = 0;
            if (in_valid) begin
                if (!m_lock) begin
                    if (sync) begin
                        q.delete();
                        q.push_back(in);
                        m_lock = 1;
                    end
                end else if (sync) begin
                    if (q.size() != 0) m_err = 1;
                    q.delete();
                    q.push_back(in);
                end else if (q.size() == 0) begin
                    m_err  = 1;
                    m_lock = 0;
                end else begin
                    q.push_back(in);
                    if (q.size() == 4) begin
                        for (int i = 0; i < 4; i++) m_out[i] = q[i];
                        m_fv = 1;
                        q.delete();
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("cyc_out", {out3, out2, out1, out0}, {m_out[3], m_out[2], m_out[1], m_out[0]});
        check("cyc_fv", frame_valid, m_fv);
        check("cyc_err", sync_err, m_err);
        check("cyc_lock", locked, m_lock);
        check("cyc_excl", frame_valid & sync_err, 1'b0);
        if (frame_valid === 1'b1) fv_cnt++;
    end

    task automatic word(input logic [W-1:0] w, input logic s);
        in = w; sync = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; sync = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk_outs(input string name, input logic [31:0] exp);
        check(name, {out3, out2, out1, out0}, exp);
    endtask

    int k;
    int fv0;

    initial begin
        rst_n = 1'b0; in = '0; in_valid = 1'b0; sync = 1'b0;
        idle(3);
        chk_outs("rst_outs", 32'h0);
        check("rst_flags", {frame_valid, locked, sync_err}, 3'b000);
        rst_n = 1'b1;

        // Hunt discard then clean frame
        word(8'hAA, 0); check("hunt_lock0", {locked, sync_err}, 2'b00);
        word(8'hBB, 0); check("hunt_lock1", {locked, sync_err}, 2'b00);
        word(8'h01, 1); check("hunt_sync_lock", locked, 1'b1);
        word(8'h02, 0); word(8'h03, 0); word(8'h04, 0);
        chk_outs("hunt_frame", 32'h04030201);
        check("hunt_fv", frame_valid, 1'b1);

        // Clean frame
        word(8'h11, 1); word(8'h22, 0); word(8'h33, 0);
        check("clean_fv_early", frame_valid, 1'b0);
        chk_outs("clean_hold", 32'h04030201);
        word(8'h44, 0);
        chk_outs("clean_outs", 32'h44332211);
        check("clean_fv", frame_valid, 1'b1);
        check("clean_lock", locked, 1'b1);
        idle(1);
        check("clean_fv_pulse", frame_valid, 1'b0);

        // Early sync
        word(8'h10, 1); word(8'h20, 0); word(8'h30, 1);
        check("early_err", sync_err, 1'b1);
        check("early_lock", locked, 1'b1);
        chk_outs("early_hold", 32'h44332211);
        word(8'h40, 0);
        check("early_err_pulse", sync_err, 1'b0);
        word(8'h50, 0); word(8'h60, 0);
        check("early_fv", frame_valid, 1'b1);
        chk_outs("early_outs", 32'h60504030);

        // Missing sync
        word(8'h77, 0);
        check("miss_err", sync_err, 1'b1);
        check("miss_lock", locked, 1'b0);
        check("miss_fv", frame_valid, 1'b0);
        chk_outs("miss_hold", 32'h60504030);

        // Gapped frame
        fv0 = fv_cnt;
        word(8'h11, 1); idle(3); word(8'h22, 0); idle(3);
        word(8'h33, 0); idle(3); word(8'h44, 0);
        chk_outs("gap_outs", 32'h44332211);
        check("gap_fv", frame_valid, 1'b1);
        idle(3);
        check("gap_fv_count", fv_cnt - fv0, 1);

        // Reset mid-frame
        word(8'h55, 1); word(8'h66, 0);
        #2 rst_n = 1'b0;
        #1;
        chk_outs("arst_outs", 32'h0);
        check("arst_flags", {frame_valid, locked, sync_err}, 3'b000);
        idle(2);
        rst_n = 1'b1;
        word(8'h77, 0); word(8'h88, 0);
        check("arst_after", {locked, sync_err, frame_valid}, 3'b000);
        chk_outs("arst_after_outs", 32'h0);

        // Randomized traffic: mostly well-formed frames with corrupted sync and resets
        k = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                #2 rst_n = 1'b0;
                #3 rst_n = 1'b1;
                k = 0;
            end
            in = W'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            sync = (k % 4 == 0);
            if ($urandom_range(0, 9) == 0) sync = ~sync;
            if (in_valid) k++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/demux1to4_tdm.md
DEMUX1TO4_TDM -- requirements
Module: demux1to4_tdm

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data width of the input word and of each output channel.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 in  input  WIDTH  SHALL carry one time-multiplexed channel word per accepted cycle.
REQ-005 in_valid  input  1  SHALL qualify in; a word is accepted only when in_valid=1.
REQ-006 sync  input  1  SHALL mark the accepted word as channel 0, the start of a frame; ignored when in_valid=0.
REQ-007 out0, out1, out2, out3  output  WIDTH each  SHALL hold the channel 0..3 words of the last complete frame.
REQ-008 frame_valid  output  1  SHALL pulse for one cycle when out0..out3 update.
REQ-009 locked  output  1  SHALL be 1 while the state machine is in LOCK.
REQ-010 sync_err  output  1  SHALL pulse for one cycle on any framing violation.

Function
REQ-011 Block SHALL contain a 2-state FSM (HUNT, LOCK), a 2-bit slot counter, four WIDTH-bit staging registers, and four WIDTH-bit output registers.
REQ-012 HUNT: accepted words with sync=0 SHALL be discarded, with no staging write, no slot change, and no sync_err.
REQ-013 HUNT, accepted word with sync=1: write staging[0], set slot=1, go to LOCK.
REQ-014 LOCK, accepted word with slot=0 and sync=1: write staging[0], set slot=1.
REQ-015 LOCK, accepted word with slot=1..3 and sync=0: write staging[slot], increment slot modulo 4 (3 wraps to 0).
REQ-016 LOCK, accepted word with slot=3 and sync=0: after the write, copy staging[0..2] and in into out0..out3 on the same edge, and assert frame_valid in the following cycle only.
REQ-017 frame_valid latency SHALL be exactly 1 cycle after the edge that accepts the slot-3 word; out0..out3 SHALL change only on that edge.
REQ-018 LOCK, accepted word with slot!=0 and sync=1 (early sync): assert sync_err for 1 cycle, discard the partial frame, write staging[0], set slot=1, stay in LOCK; out0..out3 SHALL NOT change.
REQ-019 LOCK, accepted word with slot=0 and sync=0 (missing sync): assert sync_err for 1 cycle, discard the word, go to HUNT, clear slot to 0.
REQ-020 Cycles with in_valid=0 SHALL change no state; gaps of any length inside a frame SHALL be tolerated.
REQ-021 frame_valid and sync_err SHALL never be asserted in the same cycle, since each is caused by a distinct accepted word.
REQ-022 out0..out3 SHALL hold their value indefinitely between frames, including through HUNT.
REQ-023 All outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.

Reset
REQ-024 rst_n=0 SHALL immediately force FSM=HUNT, slot=0, staging=0, out0..out3=0, frame_valid=0, locked=0, sync_err=0.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; after release, the block waits for sync in HUNT.
REQ-026 First accepted word after reset release SHALL be processed per REQ-012/013 on the first rising edge with rst_n=1.

Verification
REQ-027 Clean frame: in_valid=1 for 4 cycles, in=0x11,0x22,0x33,0x44, sync=1 on the first word -> one cycle later out0..3=0x11,0x22,0x33,0x44, frame_valid=1 for 1 cycle, locked=1.
REQ-028 Hunt discard: from reset, feed 0xAA,0xBB with sync=0, then a clean frame 0x01..0x04 -> locked stays 0 through the first two words, no sync_err, then out0..3=0x01..0x04.
REQ-029 Early sync: after lock, feed 0x10,0x20 then 0x30 with sync=1, then 0x40,0x50,0x60 -> sync_err pulse after 0x30; next frame_valid shows out0..3=0x30,0x40,0x50,0x60.
REQ-030 Missing sync: after a complete frame, feed 0x77 with sync=0 -> sync_err pulse, locked=0, out0..3 unchanged, frame_valid=0.
REQ-031 Gapped frame: clean frame with 3 idle in_valid=0 cycles between every word -> identical result to REQ-027, single frame_valid pulse.
REQ-032 Reset mid-frame: assert rst_n=0 after 2 words of a frame -> all outputs 0 asynchronously; after release, the remaining 2 words with sync=0 are discarded and locked=0.
